// File: rtl/student_tlul_sample_writer.sv
// TL-UL host that writes captured FIR samples into a word-addressed ring buffer in memory.
// Latency: a sample strobed in cycle t is on a_valid in t+1; one outstanding PutFullData; FIFO drops on full.

package student_tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PUT_FULL_DATA = 3'h0;
endpackage

module student_tlul_sample_writer
    import student_tlul_pkg::*;
#(
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int FIFO_DEPTH        = 8,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [31:0]                  base_addr_i,
    input  logic [LEN_WIDTH-1:0]         len_words_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] sample_i,
    input  logic                         sample_valid_i,
    output tl_h2d_t                      tl_o,
    input  tl_d2h_t                      tl_i,
    output logic [LEN_WIDTH-1:0]         wr_idx_o,
    output logic                         irq_o,
    output logic                         overflow_o,
    output logic                         err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]       PTR_ONE = (PTR_W+1)'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                       state;
    logic [DATA_SIZE_FIR_OUT-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]               wr_ptr, rd_ptr;
    logic [31:0]                  base_q;
    logic [LEN_WIDTH-1:0]         len_q, len_eff, wr_idx, idx_next;
    logic                         irq_q, overflow_q, err_q;
    logic                         fifo_empty, fifo_full, push, pop, idx_wrap, half_hit;
    logic                         unused_tl;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = (state == REQ) && tl_i.a_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = sample_valid_i && enable_i && (!fifo_full || pop);

    assign len_eff  = (len_q == '0) ? LEN_ONE : len_q;
    assign idx_wrap = (wr_idx >= len_eff - LEN_ONE);
    assign idx_next = idx_wrap ? '0 : wr_idx + LEN_ONE;
    assign half_hit = (len_eff >= LEN_TWO) && (idx_next == (len_eff >> 1));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            wr_idx     <= '0;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (sample_valid_i && enable_i && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!enable_i) begin
                        // Ring geometry only moves while idle and disabled, so a held request never shifts.
                        base_q     <= {base_addr_i[31:2], 2'b00};
                        len_q      <= len_words_i;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        wr_idx     <= '0;
                        overflow_q <= 1'b0;
                        err_q      <= 1'b0;
                    end else if (!fifo_empty || push) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (tl_i.a_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (tl_i.d_valid) begin
                        state  <= IDLE;
                        wr_idx <= idx_next;
                        irq_q  <= idx_wrap || half_hit;
                        if (tl_i.d_error) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state == REQ);
        tl_o.a_opcode  = PUT_FULL_DATA;
        tl_o.a_size    = 2'd2;
        tl_o.a_mask    = 4'hF;
        tl_o.a_address = base_q + 32'({wr_idx, 2'b00});
        tl_o.a_data    = 32'(mem[rd_ptr[PTR_W-1:0]]);
        tl_o.d_ready   = (state == RESP);
    end

    assign wr_idx_o   = wr_idx;
    assign irq_o      = irq_q;
    assign overflow_o = overflow_q;
    assign err_o      = err_q;

    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_data, tl_i.d_user, base_addr_i[1:0]};

endmodule

// File: tb/tb_student_tlul_sample_writer.sv
// Bench for student_tlul_sample_writer: random samples against a ring-buffer reference model.
module tb_student_tlul_sample_writer;
    import student_tlul_pkg::*;

    logic        clk, rst_n, enable, sample_valid;
    logic [31:0] base_addr, sample;
    logic [15:0] len_words, wr_idx;
    logic        irq, overflow, err;
    tl_h2d_t     tl_h2d;
    tl_d2h_t     tl_d2h;

    logic        a_ready, d_valid, d_error;
    bit          stall, d_hold, pend, held;
    int          err_at, hs_count, proto_err, stable_err, d_delay;
    logic [31:0] held_addr, held_data;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          irq_q[$];
    int          compared, mismatched;

    student_tlul_sample_writer dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .base_addr_i(base_addr),
        .len_words_i(len_words), .sample_i(sample), .sample_valid_i(sample_valid),
        .tl_o(tl_h2d), .tl_i(tl_d2h), .wr_idx_o(wr_idx), .irq_o(irq),
        .overflow_o(overflow), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        tl_d2h         = '0;
        tl_d2h.a_ready = a_ready;
        tl_d2h.d_valid = d_valid;
        tl_d2h.d_error = d_error;
    end

    // Memory-side device: random a_ready, random response delay, records every accepted write.
    initial begin
        a_ready = 0; d_valid = 0; d_error = 0; pend = 0; held = 0;
        hs_count = 0; proto_err = 0; stable_err = 0; d_delay = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_ready = 0; d_valid = 0; d_error = 0; pend = 0; held = 0;
            end else begin
                if (irq) irq_q.push_back(hs_count);
                if (tl_h2d.a_valid && tl_h2d.d_ready) proto_err++;
                if (d_valid) begin
                    d_valid = 0; d_error = 0;
                end
                if (a_ready) begin
                    a_ready = 0; pend = 1; held = 0; d_delay = $urandom_range(0, 2);
                end
                if (pend && !d_hold) begin
                    if (d_delay == 0) begin
                        pend = 0; hs_count++; d_valid = 1; d_error = (hs_count == err_at);
                    end else begin
                        d_delay--;
                    end
                end
                if (tl_h2d.a_valid) begin
                    if (held && (tl_h2d.a_address != held_addr || tl_h2d.a_data != held_data))
                        stable_err++;
                    if (!stall && $urandom_range(0, 3) != 0) begin
                        a_ready = 1; held = 0;
                        wq_addr.push_back(tl_h2d.a_address);
                        wq_data.push_back(tl_h2d.a_data);
                    end else begin
                        held = 1; held_addr = tl_h2d.a_address; held_data = tl_h2d.a_data;
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] v, input int gap);
        sample = v; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic configure(input logic [31:0] base, input logic [15:0] len);
        enable = 0; base_addr = base; len_words = len;
        repeat (3) @(negedge clk);
        wq_addr.delete(); wq_data.delete(); irq_q.delete();
        hs_count = 0; err_at = 0;
        enable = 1;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int c = 0;
        while (hs_count < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check(tag, hs_count, n);
    endtask

    // Reference: write k lands at base + 4*(k mod L); write k (1-based) pulses irq when
    // the new index is 0 or L/2 (L >= 2).
    task automatic run_stream(input logic [31:0] base, input logic [15:0] len, input int n);
        logic [31:0] exp_data[$];
        int          exp_irq[$];
        int          L, nidx;
        logic [31:0] a;
        configure(base, len);
        L = (len == 0) ? 1 : int'(len);
        for (int k = 0; k < n; k++) begin
            exp_data.push_back($urandom);
            send(exp_data[k], 8);
        end
        wait_writes(n, 300, "stream_resp_count");
        check("stream_write_count", wq_data.size(), n);
        for (int k = 0; k < n && k < wq_data.size(); k++) begin
            a = {base[31:2], 2'b00} + 32'(4 * (k % L));
            check("stream_addr", wq_addr[k], a);
            check("stream_data", wq_data[k], exp_data[k]);
        end
        for (int k = 1; k <= n; k++) begin
            nidx = k % L;
            if (nidx == 0 || (L >= 2 && nidx == L / 2)) exp_irq.push_back(k);
        end
        check("stream_irq_count", irq_q.size(), exp_irq.size());
        for (int i = 0; i < exp_irq.size() && i < irq_q.size(); i++)
            check("stream_irq_at_write", irq_q[i], exp_irq[i]);
        check("stream_wr_idx", wr_idx, n % L);
    endtask

    initial begin
        logic [31:0] bp[10];
        logic [31:0] v1;
        int          c, av;
        compared = 0; mismatched = 0;
        stall = 0; d_hold = 0; err_at = 0;
        rst_n = 0; enable = 0; sample_valid = 0; sample = 0;
        base_addr = 0; len_words = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("reset_a_valid", tl_h2d.a_valid, 0);
        check("reset_d_ready", tl_h2d.d_ready, 0);
        check("reset_wr_idx", wr_idx, 0);
        check("reset_irq", irq, 0);
        check("reset_overflow", overflow, 0);
        check("reset_err", err, 0);

        // Single write: visible on the bus the cycle after the strobe.
        configure(32'h1000_0000, 16'd4);
        sample = 32'h0000_ABCD; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        check("single_a_valid", tl_h2d.a_valid, 1);
        check("single_addr", tl_h2d.a_address, 32'h1000_0000);
        check("single_data", tl_h2d.a_data, 32'h0000_ABCD);
        check("single_opcode", tl_h2d.a_opcode, 3'h0);
        check("single_size", tl_h2d.a_size, 2'd2);
        check("single_mask", tl_h2d.a_mask, 4'hF);
        wait_writes(1, 50, "single_resp");
        check("single_wr_idx", wr_idx, 1);
        check("single_no_irq", irq_q.size(), 0);

        run_stream(32'h1000_0000, 16'd4, 5);
        run_stream($urandom, 16'd0, 3);
        run_stream($urandom, 16'($urandom_range(2, 7)), 9);
        run_stream($urandom, 16'd2, 4);

        // Backpressure: the head is stuck on the bus while the FIFO fills and then drops.
        configure(32'h4000_0100, 16'd16);
        stall = 1;
        for (int i = 0; i < 10; i++) begin
            bp[i] = $urandom;
            send(bp[i], 0);
        end
        repeat (10) @(negedge clk);
        check("bp_overflow", overflow, 1);
        check("bp_held_addr", tl_h2d.a_address, 32'h4000_0100);
        check("bp_held_data", tl_h2d.a_data, bp[0]);
        stall = 0;
        wait_writes(8, 200, "bp_resp_count");
        repeat (10) @(negedge clk);
        check("bp_exact_writes", wq_data.size(), 8);
        for (int k = 0; k < 8 && k < wq_data.size(); k++) begin
            check("bp_data", wq_data[k], bp[k]);
            check("bp_addr", wq_addr[k], 32'h4000_0100 + 32'(4 * k));
        end

        // Error response on the second write; disabling first must clear the overflow flag.
        configure(32'h0800_0000, 16'd8);
        check("disable_clears_overflow", overflow, 0);
        err_at = 2;
        send($urandom, 8);
        wait_writes(1, 50, "err_first_resp");
        check("err_clear_after_ok", err, 0);
        send($urandom, 8);
        send($urandom, 8);
        wait_writes(3, 100, "err_resp_count");
        check("err_sticky", err, 1);
        check("err_wr_idx_advances", wr_idx, 3);
        check("err_third_written", wq_data.size(), 3);
        err_at = 0;

        // Asynchronous reset while waiting for a response, with flags set.
        d_hold = 1;
        send($urandom, 0);
        c = 0;
        while (!tl_h2d.d_ready && c < 30) begin
            @(negedge clk);
            c++;
        end
        check("rst_reached_resp", tl_h2d.d_ready, 1);
        for (int i = 0; i < 9; i++) send($urandom, 0);
        check("rst_pre_overflow", overflow, 1);
        #2 rst_n = 0;
        #1;
        check("rst_a_valid", tl_h2d.a_valid, 0);
        check("rst_d_ready", tl_h2d.d_ready, 0);
        check("rst_wr_idx", wr_idx, 0);
        check("rst_irq", irq, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        d_hold = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Disable while a request is pending: the request must complete, queued data is flushed.
        configure(32'h2000_0040, 16'd8);
        stall = 1;
        v1 = $urandom;
        send(v1, 0);
        send($urandom, 0);
        c = 0;
        while (!tl_h2d.a_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("dis_req_up", tl_h2d.a_valid, 1);
        enable = 0;
        repeat (5) @(negedge clk);
        check("dis_req_held", tl_h2d.a_valid, 1);
        check("dis_addr_held", tl_h2d.a_address, 32'h2000_0040);
        check("dis_data_held", tl_h2d.a_data, v1);
        stall = 0;
        wait_writes(1, 50, "dis_resp");
        check("dis_wr_idx_zero", wr_idx, 0);
        check("dis_one_write", wq_data.size(), 1);
        if (wq_data.size() > 0) check("dis_write_data", wq_data[0], v1);
        send($urandom, 0);
        av = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (tl_h2d.a_valid) av++;
        end
        check("dis_no_new_a_valid", av, 0);
        check("dis_no_more_writes", wq_data.size(), 1);

        check("a_channel_stable", stable_err, 0);
        check("single_outstanding", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
